msj_hbridge_pwm: RTL and testbench

MSJ_HBRIDGE_PWM -- requirements
Module: msj_hbridge_pwm

---
 rtl/msj_hbridge_pwm.sv | 141 ++++++++++++++
 tb/tb_msj_hbridge_pwm.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msj_hbridge_pwm.sv
// H-bridge PWM driver: slew-limited signed duty, dead time on direction reversal,
// and a synchronised emergency kill that parks the bridge until a new request arrives.
module msj_hbridge_pwm #(
    parameter int CLOCK_SPEED_HZ   = 50_000_000,
    parameter int PWM_FREQ_HZ      = 16000,
    parameter int SLEW_STEP        = 64,
    parameter int DEAD_TIME_CYCLES = 50
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ena,
    input  logic signed [31:0] duty,
    input  logic               emergency_off,
    output logic               pwm_a,
    output logic               pwm_b,
    output logic               dir,
    output logic               period_start,
    output logic               at_setpoint,
    output logic               fault
);
    localparam int PERIOD = CLOCK_SPEED_HZ / PWM_FREQ_HZ;
    localparam int CW     = $clog2(PERIOD + 1);
    localparam int DW     = $clog2(DEAD_TIME_CYCLES + 1);
    localparam logic signed [31:0] PER_S  = 32'(PERIOD);
    localparam logic signed [31:0] STEP_S = 32'(SLEW_STEP);

    typedef enum logic [1:0] {IDLE, FWD, REV, DEAD} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      dead_q, dead_d;
    logic signed [31:0] req_q, req_d, act_q, act_d;
    logic               last_rev_q, last_rev_d;
    logic               sync1_q, sync2_q;
    logic               pwm_a_q, pwm_b_q, dir_q, ps_q;

    logic               wrap;
    logic signed [31:0] cnt_ext, act_mag, diff, step, slew, duty_clamped;

    assign wrap    = (cnt_q == CW'(PERIOD - 1));
    assign cnt_ext = {{(32 - CW){1'b0}}, cnt_q};

    // Opposite signs first decay toward zero; the reversal itself goes through DEAD.
    always_comb begin
        act_mag = act_q[31] ? -act_q : act_q;
        diff    = req_q - act_q;
        step    = (act_mag < STEP_S) ? act_mag : STEP_S;
        slew    = req_q;
        if (req_q != 0 && act_q != 0 && req_q[31] != act_q[31])
            slew = act_q[31] ? act_q + step : act_q - step;
        else if (diff > STEP_S)
            slew = act_q + STEP_S;
        else if (diff < -STEP_S)
            slew = act_q - STEP_S;
    end

    always_comb begin
        duty_clamped = duty;
        if (duty > PER_S)
            duty_clamped = PER_S;
        else if (duty < -PER_S)
            duty_clamped = -PER_S;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = wrap ? '0 : cnt_q + CW'(1);
        dead_d     = dead_q;
        req_d      = req_q;
        act_d      = act_q;
        last_rev_d = last_rev_q;
        if (state_q == DEAD)
            cnt_d = '0;
        if (sync2_q) begin
            req_d   = '0;
            act_d   = '0;
            dead_d  = '0;
            state_d = IDLE;
        end else begin
            if (ena)
                req_d = duty_clamped;
            if (state_q == DEAD) begin
                if (dead_q == DW'(DEAD_TIME_CYCLES - 1)) begin
                    state_d    = act_q[31] ? REV : FWD;
                    last_rev_d = act_q[31];
                end else begin
                    dead_d = dead_q + DW'(1);
                end
            end else if (wrap) begin
                act_d = slew;
                if (slew == 0) begin
                    state_d = IDLE;
                end else if (state_q == IDLE) begin
                    if (slew[31] == last_rev_q) begin
                        state_d = slew[31] ? REV : FWD;
                    end else begin
                        state_d = DEAD;
                        dead_d  = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dead_q     <= '0;
            req_q      <= '0;
            act_q      <= '0;
            last_rev_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            pwm_a_q    <= 1'b0;
            pwm_b_q    <= 1'b0;
            dir_q      <= 1'b0;
            ps_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dead_q     <= dead_d;
            req_q      <= req_d;
            act_q      <= act_d;
            last_rev_q <= last_rev_d;
            sync1_q    <= emergency_off;
            sync2_q    <= sync1_q;
            pwm_a_q    <= !sync2_q && state_q == FWD && cnt_ext < act_q;
            pwm_b_q    <= !sync2_q && state_q == REV && cnt_ext < -act_q;
            dir_q      <= !sync2_q && state_q == REV;
            ps_q       <= state_q != DEAD && cnt_q == '0;
        end
    end

    assign pwm_a        = pwm_a_q;
    assign pwm_b        = pwm_b_q;
    assign dir          = dir_q;
    assign period_start = ps_q;
    assign fault        = sync2_q;
    assign at_setpoint  = (act_q == req_q);
endmodule

// File: tb/tb_msj_hbridge_pwm.sv
// Bench for msj_hbridge_pwm: directed scenarios followed by random requests and kills,
// every output compared each cycle against a period-level reference model.
module tb_msj_hbridge_pwm;
    localparam int CLK_HZ = 1_600_000;
    localparam int PWM_HZ = 16000;
    localparam int P      = CLK_HZ / PWM_HZ;
    localparam int STEP   = 16;
    localparam int DEAD   = 10;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               ena = 1'b0;
    logic signed [31:0] duty = '0;
    logic               emergency_off = 1'b0;
    logic               pwm_a, pwm_b, dir, period_start, at_setpoint, fault;

    int checks = 0;
    int failures = 0;

    msj_hbridge_pwm #(
        .CLOCK_SPEED_HZ(CLK_HZ), .PWM_FREQ_HZ(PWM_HZ),
        .SLEW_STEP(STEP), .DEAD_TIME_CYCLES(DEAD)
    ) dut (
        .clock(clock), .reset(reset), .ena(ena), .duty(duty),
        .emergency_off(emergency_off), .pwm_a(pwm_a), .pwm_b(pwm_b), .dir(dir),
        .period_start(period_start), .at_setpoint(at_setpoint), .fault(fault)
    );

    always #5 clock = ~clock;

    // Reference model: position in period, requested/applied duty, dead-time countdown.
    int   m_cnt, m_req, m_act, m_dead;
    logic m_last_rev, m_s1, m_s2;
    logic e_a, e_b, e_dir, e_ps;

    function automatic int clamp(input logic signed [31:0] d);
        if (d > P) return P;
        if (d < -P) return -P;
        return d;
    endfunction

    function automatic int slew(input int req, input int act);
        int mag, st;
        if ((req > 0 && act < 0) || (req < 0 && act > 0)) begin
            mag = (act > 0) ? act : -act;
            st  = (mag < STEP) ? mag : STEP;
            return (act > 0) ? act - st : act + st;
        end
        if (req - act > STEP) return act + STEP;
        if (req - act < -STEP) return act - STEP;
        return req;
    endfunction

    task automatic model_step();
        int nc, nact, nreq, ndead;
        logic nlast;
        e_a   <= !m_s2 && m_dead == 0 && m_act > 0 && m_cnt < m_act;
        e_b   <= !m_s2 && m_dead == 0 && m_act < 0 && m_cnt < -m_act;
        e_dir <= !m_s2 && m_dead == 0 && m_act < 0;
        e_ps  <= m_cnt == 0 && m_dead == 0;
        nc    = (m_dead > 0 || m_cnt == P - 1) ? 0 : m_cnt + 1;
        nact  = m_act;
        nreq  = m_req;
        ndead = m_dead;
        nlast = m_last_rev;
        if (m_s2) begin
            nact = 0; nreq = 0; ndead = 0;
        end else begin
            if (m_dead > 0) begin
                ndead = m_dead - 1;
                if (ndead == 0) nlast = (m_act < 0);
            end else if (m_cnt == P - 1) begin
                nact = slew(m_req, m_act);
                if (m_act == 0 && nact != 0 && ((nact < 0) != m_last_rev)) ndead = DEAD;
                else if (nact != 0) nlast = (nact < 0);
            end
            if (ena) nreq = clamp(duty);
        end
        m_cnt      <= nc;
        m_act      <= nact;
        m_req      <= nreq;
        m_dead     <= ndead;
        m_last_rev <= nlast;
        m_s1       <= emergency_off;
        m_s2       <= m_s1;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt <= 0; m_req <= 0; m_act <= 0; m_dead <= 0;
            m_last_rev <= 1'b0; m_s1 <= 1'b0; m_s2 <= 1'b0;
            e_a <= 1'b0; e_b <= 1'b0; e_dir <= 1'b0; e_ps <= 1'b0;
        end else begin
            model_step();
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
        chk("pwm_a", pwm_a, e_a);
        chk("pwm_b", pwm_b, e_b);
        chk("dir", dir, e_dir);
        chk("period_start", period_start, e_ps);
        chk("fault", fault, m_s2);
        chk("at_setpoint", at_setpoint, m_act == m_req);
        chk("no_overlap", pwm_a & pwm_b, 1'b0);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse_ena(input logic signed [31:0] d);
        ena = 1'b1;
        duty = d;
        cyc();
        ena = 1'b0;
    endtask

    task automatic wait_ps(input int limit);
        int k;
        logic ok;
        k = 0;
        ok = 1'b0;
        while (k < limit && !ok) begin
            cyc();
            if (period_start) ok = 1'b1;
            k++;
        end
        chk("wait_period_start", ok, 1'b1);
    endtask

    // Counts high cycles of each output over one whole period starting at period_start.
    task automatic count_period(input string tag, input int exp_a, input int exp_b);
        int na, nb;
        wait_ps(2 * P + DEAD + 5);
        na = int'(pwm_a);
        nb = int'(pwm_b);
        repeat (P - 1) begin
            cyc();
            na += int'(pwm_a);
            nb += int'(pwm_b);
        end
        chk_int({tag, "_a_high"}, na, exp_a);
        chk_int({tag, "_b_high"}, nb, exp_b);
    endtask

    initial begin
        int k, eoff_left;
        logic found;

        run(3);
        chk("reset_pwm_a", pwm_a, 1'b0);
        chk("reset_at_setpoint", at_setpoint, 1'b1);
        reset = 1'b0;
        cyc();
        chk("first_period_start", period_start, 1'b1);

        // Ramp to a forward duty in slew-limited steps.
        pulse_ena(60);
        run(5 * P);
        count_period("fwd60", 60, 0);

        // Reversal through zero and dead time.
        pulse_ena(32);
        run(3 * P);
        pulse_ena(-32);
        run(6 * P);
        count_period("rev32", 0, 32);
        chk("rev_dir", dir, 1'b1);

        // Clamping at both extremes gives a constant-high output.
        pulse_ena(5000);
        run(12 * P);
        count_period("clamp_pos", P, 0);
        pulse_ena(32'sh8000_0000);
        run(17 * P);
        count_period("clamp_neg", 0, P);

        // Emergency kill mid-period; ena ignored while asserted; no restart on release.
        pulse_ena(40);
        run(12 * P);
        count_period("pre_kill", 40, 0);
        wait_ps(P + 5);
        run(20);
        emergency_off = 1'b1;
        run(3);
        chk("kill_pwm_a", pwm_a, 1'b0);
        chk("kill_pwm_b", pwm_b, 1'b0);
        chk("kill_fault", fault, 1'b1);
        pulse_ena(40);
        run(P);
        emergency_off = 1'b0;
        run(3 * P);
        count_period("after_kill", 0, 0);
        pulse_ena(40);
        run(4 * P);
        count_period("resume", 40, 0);

        // Reset while in dead time, then a reverse request after release.
        pulse_ena(-16);
        k = 0;
        found = 1'b0;
        while (k < 10 * P && !found) begin
            cyc();
            if (m_dead > 0) found = 1'b1;
            k++;
        end
        chk("reached_dead", found, 1'b1);
        run(3);
        reset = 1'b1;
        #1;
        chk("rst_pwm_a", pwm_a, 1'b0);
        chk("rst_pwm_b", pwm_b, 1'b0);
        chk("rst_dir", dir, 1'b0);
        chk("rst_period_start", period_start, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_at_setpoint", at_setpoint, 1'b1);
        run(2);
        reset = 1'b0;
        run(2);
        pulse_ena(-16);
        run(2 * P);
        count_period("post_rst_rev", 0, 16);

        // Random requests and occasional kills against the model.
        eoff_left = 0;
        repeat (3000) begin
            cyc();
            ena = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) duty = $urandom;
            else duty = 32'(int'($urandom_range(0, 300)) - 150);
            if (eoff_left > 0) begin
                eoff_left--;
                if (eoff_left == 0) emergency_off = 1'b0;
            end else if ($urandom_range(0, 999) == 0) begin
                emergency_off = 1'b1;
                eoff_left = int'($urandom_range(5, 30));
            end
        end
        ena = 1'b0;
        emergency_off = 1'b0;
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout reached before end of test");
        $fatal(1, "timeout");
    end
endmodule
